// File: rtl/coverage_stall_monitor_pkg.sv
// Shared types for the coverage stall monitor: FSM states,
// cause encodings and a width-generic saturating increment.
package cov_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRED,
        COOL
    } mon_state_t;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_NONE  = 2'b00;
    localparam cause_t CAUSE_STALL = 2'b01;
    localparam cause_t CAUSE_WDOG  = 2'b10;
    localparam cause_t CAUSE_BOTH  = 2'b11;

    // Increment v, holding at 2**w-1.
    function automatic logic [63:0] sat_inc(
        input logic [63:0] v,
        input int          w
    );
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= lim) ? lim : v + 64'd1;
    endfunction

endpackage

// File: rtl/coverage_stall_monitor_if.sv
// Probe/interrupt bundle of the coverage stall monitor.
// master: probe/ack driver; slave: the monitor.
interface coverage_stall_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int COV_W  = 30
);
    logic                      enable;
    logic                      round_start;
    logic [NUM_CH-1:0]         ch_mask;
    logic [NUM_CH*COV_W-1:0]   cov;
    logic [63:0]               tohost;
    logic                      irq_ack;
    logic                      interrupt;
    logic [1:0]                cause;
    logic [NUM_CH-1:0]         stall_vec;

    modport master (
        output enable, round_start, ch_mask, cov, tohost, irq_ack,
        input  interrupt, cause, stall_vec
    );

    modport slave (
        input  enable, round_start, ch_mask, cov, tohost, irq_ack,
        output interrupt, cause, stall_vec
    );
endinterface

// File: rtl/coverage_stall_monitor_channel.sv
// One coverage probe channel: tracks last value, counts idle cycles,
// compares against a coverage-scaled threshold.
// Ports: clock, reset_n, clr (restart), freeze (hold), tclr (tohost
// clear), mask, cov (probe) -> stall (masked over-threshold flag).
module cov_stall_channel
    import cov_mon_pkg::*;
#(
    parameter int COV_W       = 30,
    parameter int CNT_W       = 32,
    parameter int BASE_WAIT   = 1000,
    parameter int SCALE_SHIFT = 19
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             freeze,
    input  logic             tclr,
    input  logic             mask,
    input  logic [COV_W-1:0] cov,
    output logic             stall
);
    localparam int TW = CNT_W + COV_W;

    logic [COV_W-1:0] pre_cov;
    logic [CNT_W-1:0] cnt;
    logic [TW-1:0]    thr_full;
    logic [CNT_W-1:0] thr;

    // Wide product cannot overflow; clamp into counter range.
    assign thr_full = TW'(BASE_WAIT)
                    * (TW'(cov >> SCALE_SHIFT) + TW'(1));
    assign thr = (|thr_full[TW-1:CNT_W]) ? '1
                                         : thr_full[CNT_W-1:0];
    assign stall = mask & (cnt >= thr);

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            pre_cov <= '0;
        end else if (clr) begin
            cnt     <= '0;
            pre_cov <= cov;
        end else if (!freeze) begin
            if (cov != pre_cov) pre_cov <= cov;
            if (tclr || (cov != pre_cov)) cnt <= '0;
            else cnt <= CNT_W'(sat_inc(64'(cnt), CNT_W));
        end
    end

endmodule

// File: rtl/coverage_stall_monitor.sv
// Multi-channel coverage stall / round watchdog interrupt source.
// Ports: clock, reset_n, bus (slave): enable, round_start, ch_mask,
// cov, tohost, irq_ack in; interrupt, cause, stall_vec out.
module coverage_stall_monitor
    import cov_mon_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int COV_W       = 30,
    parameter int CNT_W       = 32,
    parameter int BASE_WAIT   = 1000,
    parameter int SCALE_SHIFT = 19,
    parameter int WDOG_LIMIT  = 50000,
    parameter int PULSE_MODE  = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    coverage_stall_monitor_if.slave bus
);
    localparam logic [CNT_W+31:0] WLIM = (CNT_W+32)'(WDOG_LIMIT);

    mon_state_t        state;
    logic [CNT_W-1:0]  wdog;
    logic [NUM_CH-1:0] stall_w;
    logic              clr;
    logic              freeze;
    logic              stall_hit;
    logic              wdog_hit;
    cause_t            hit_cause;
    logic              unused_tohost;

    assign unused_tohost = ^bus.tohost[63:1];

    // Disable, new round and the cool-down state all restart counting.
    assign clr    = !bus.enable || bus.round_start || (state == COOL);
    assign freeze = (state == FIRED);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cov_stall_channel #(
            .COV_W       (COV_W),
            .CNT_W       (CNT_W),
            .BASE_WAIT   (BASE_WAIT),
            .SCALE_SHIFT (SCALE_SHIFT)
        ) u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (clr),
            .freeze  (freeze),
            .tclr    (bus.tohost[0]),
            .mask    (bus.ch_mask[i]),
            .cov     (bus.cov[i*COV_W +: COV_W]),
            .stall   (stall_w[i])
        );
    end

    assign bus.stall_vec = stall_w;

    // Empty mask never counts as "all stalled".
    assign stall_hit = (|bus.ch_mask) & (&(stall_w | ~bus.ch_mask));
    assign wdog_hit  = ({32'd0, wdog} >= WLIM);

    always_comb begin
        hit_cause = CAUSE_NONE;
        if (stall_hit && wdog_hit) hit_cause = CAUSE_BOTH;
        else if (wdog_hit)         hit_cause = CAUSE_WDOG;
        else if (stall_hit)        hit_cause = CAUSE_STALL;
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wdog <= '0;
        end else if (clr) begin
            wdog <= '0;
        end else if (!freeze) begin
            if (bus.tohost[0]) wdog <= '0;
            else wdog <= CNT_W'(sat_inc(64'(wdog), CNT_W));
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bus.interrupt <= 1'b0;
            bus.cause     <= CAUSE_NONE;
        end else if (!bus.enable) begin
            state         <= IDLE;
            bus.interrupt <= 1'b0;
            bus.cause     <= CAUSE_NONE;
        end else if (bus.round_start) begin
            state         <= ARMED;
            bus.interrupt <= 1'b0;
            bus.cause     <= CAUSE_NONE;
        end else begin
            unique case (state)
                IDLE: state <= ARMED;
                ARMED: begin
                    if (stall_hit || wdog_hit) begin
                        state         <= FIRED;
                        bus.interrupt <= 1'b1;
                        bus.cause     <= hit_cause;
                    end
                end
                FIRED: begin
                    // Pulse mode: high only on the entry cycle.
                    if (PULSE_MODE != 0) bus.interrupt <= 1'b0;
                    if (bus.irq_ack) begin
                        state         <= COOL;
                        bus.interrupt <= 1'b0;
                    end
                end
                COOL: begin
                    state     <= ARMED;
                    bus.cause <= CAUSE_NONE;
                end
            endcase
        end
    end

endmodule
